// File: rtl/traffic_light_monitor_pkg.sv
// Shared lamp encodings, fault codes and small helpers for the traffic light monitor.
package traffic_pkg;

  localparam int unsigned LIGHT_W = 3;
  localparam int unsigned CODE_W  = 3;

  typedef logic [LIGHT_W-1:0] light_t;

  localparam light_t L_RED = 3'b100;
  localparam light_t L_YEL = 3'b010;
  localparam light_t L_GRN = 3'b001;

  typedef enum logic [CODE_W-1:0] {
    FLT_NONE     = 3'd0,
    FLT_ENC      = 3'd1,
    FLT_CONFLICT = 3'd2,
    FLT_TRANS    = 3'd3,
    FLT_YELLOW   = 3'd4,
    FLT_GREEN    = 3'd5,
    FLT_ALLRED   = 3'd6
  } fault_code_t;

  // Per-direction violation flags reported by each direction tracker
  typedef struct packed {
    logic enc_err;
    logic trans_err;
    logic yel_err;
    logic grn_err;
  } dir_flags_t;

  function automatic logic is_onehot3(input light_t l);
    return (l == L_RED) || (l == L_YEL) || (l == L_GRN);
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp bus between the light controller (master) and its observers (slave).
interface traffic_light_monitor_if;
  import traffic_pkg::*;

  light_t ns_light;
  light_t ew_light;

  modport master (output ns_light, output ew_light);
  modport slave  (input  ns_light, input  ew_light);

endinterface

// File: rtl/traffic_light_monitor_dir_tracker.sv
// One lamp direction: colour history, dwell counter and per-direction legality checks.
module light_dir_tracker
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned YELLOW_TICKS    = 2,
  parameter int unsigned YELLOW_TOL      = 1,
  parameter int unsigned GREEN_MAX_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             tick_1hz,
  input  light_t           light,
  output dir_flags_t       flags_c,
  output logic [CNT_W-1:0] dwell
);

  localparam logic [CNT_W-1:0] YEL_MIN     = CNT_W'(YELLOW_TICKS - YELLOW_TOL);
  localparam logic [CNT_W-1:0] YEL_MAX     = CNT_W'(YELLOW_TICKS + YELLOW_TOL);
  localparam logic [CNT_W-1:0] GREEN_LIMIT = CNT_W'(GREEN_MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] DWELL_MAX   = '1;

  // COL_NONE means no legal colour seen since reset (prev_valid = 0)
  typedef enum logic [1:0] {
    COL_NONE = 2'd0,
    COL_RED  = 2'd1,
    COL_YEL  = 2'd2,
    COL_GRN  = 2'd3
  } col_state_t;

  col_state_t       state, state_nxt, cur_col;
  logic [CNT_W-1:0] dwell_nxt;
  logic             grn_fired, grn_fired_nxt;
  logic             valid_c, changed_c;

  function automatic logic legal_step(input col_state_t from, input col_state_t to);
    return ((from == COL_GRN) && (to == COL_YEL)) ||
           ((from == COL_YEL) && (to == COL_RED)) ||
           ((from == COL_RED) && (to == COL_GRN));
  endfunction

  // Decode the sampled lamp word into a colour
  always_comb begin
    cur_col = COL_NONE;
    unique case (light)
      L_RED:   cur_col = COL_RED;
      L_YEL:   cur_col = COL_YEL;
      L_GRN:   cur_col = COL_GRN;
      default: cur_col = COL_NONE;
    endcase
  end

  assign valid_c = en && is_onehot3(light);

  // Next colour state, dwell and violation flags
  always_comb begin
    state_nxt     = state;
    dwell_nxt     = dwell;
    grn_fired_nxt = grn_fired;
    flags_c       = '0;
    changed_c     = 1'b0;

    if (en) begin
      flags_c.enc_err = !valid_c;
      if (valid_c) begin
        state_nxt = cur_col;
        changed_c = (state != COL_NONE) && (cur_col != state);
        if (changed_c) begin
          flags_c.trans_err = !legal_step(state, cur_col);
        end
        if ((state == COL_YEL) && (cur_col == COL_RED)) begin
          flags_c.yel_err = (dwell < YEL_MIN) || (dwell > YEL_MAX);
        end
        if (!changed_c && (cur_col == COL_GRN) && !grn_fired && (dwell >= GREEN_LIMIT)) begin
          flags_c.grn_err = 1'b1;
          grn_fired_nxt   = 1'b1;
        end
      end

      if (changed_c) begin
        dwell_nxt     = '0;
        grn_fired_nxt = 1'b0;
      end else if (tick_1hz && (dwell != DWELL_MAX)) begin
        dwell_nxt = dwell + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= COL_NONE;
      dwell     <= '0;
      grn_fired <= 1'b0;
    end else begin
      state     <= state_nxt;
      dwell     <= dwell_nxt;
      grn_fired <= grn_fired_nxt;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp safety checker: samples both directions, flags violations, latches first fault.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W            = 8,
  parameter int unsigned YELLOW_TICKS     = 2,
  parameter int unsigned YELLOW_TOL       = 1,
  parameter int unsigned GREEN_MAX_TICKS  = 10,
  parameter int unsigned ALLRED_MAX_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick_1hz,
  input  logic                    fault_clr,
  traffic_light_monitor_if.slave  lights,
  output logic                    fault,
  output logic [CODE_W-1:0]       fault_code,
  output logic [CNT_W-1:0]        fault_count,
  output logic [CNT_W-1:0]        ns_dwell,
  output logic [CNT_W-1:0]        ew_dwell
);

  localparam logic [CNT_W-1:0] ALLRED_LIMIT = CNT_W'(ALLRED_MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  light_t           ns_s, ew_s;
  logic             s_vld;
  logic [CNT_W-1:0] allred_cnt, allred_cnt_nxt;
  logic             allred_fired, allred_fired_nxt;
  dir_flags_t       ns_flags_c, ew_flags_c;
  logic             conflict_c, both_red_c, allred_err_c;
  fault_code_t      code_c;

  // Stage S: register both lamp buses; s_vld masks the cleared sample after reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ns_s  <= '0;
      ew_s  <= '0;
      s_vld <= 1'b0;
    end else begin
      ns_s  <= lights.ns_light;
      ew_s  <= lights.ew_light;
      s_vld <= 1'b1;
    end
  end

  light_dir_tracker #(
    .CNT_W           (CNT_W),
    .YELLOW_TICKS    (YELLOW_TICKS),
    .YELLOW_TOL      (YELLOW_TOL),
    .GREEN_MAX_TICKS (GREEN_MAX_TICKS)
  ) u_ns (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (s_vld),
    .tick_1hz (tick_1hz),
    .light    (ns_s),
    .flags_c  (ns_flags_c),
    .dwell    (ns_dwell)
  );

  light_dir_tracker #(
    .CNT_W           (CNT_W),
    .YELLOW_TICKS    (YELLOW_TICKS),
    .YELLOW_TOL      (YELLOW_TOL),
    .GREEN_MAX_TICKS (GREEN_MAX_TICKS)
  ) u_ew (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (s_vld),
    .tick_1hz (tick_1hz),
    .light    (ew_s),
    .flags_c  (ew_flags_c),
    .dwell    (ew_dwell)
  );

  assign conflict_c = s_vld && (ns_s != L_RED) && (ew_s != L_RED);
  assign both_red_c = s_vld && (ns_s == L_RED) && (ew_s == L_RED);

  // Shared all-red dwell with a one-shot fault per all-red interval
  always_comb begin
    allred_cnt_nxt   = '0;
    allred_fired_nxt = 1'b0;
    allred_err_c     = 1'b0;
    if (both_red_c) begin
      allred_err_c     = !allred_fired && (allred_cnt >= ALLRED_LIMIT);
      allred_fired_nxt = allred_fired || allred_err_c;
      allred_cnt_nxt   = allred_cnt;
      if (tick_1hz && (allred_cnt != CNT_MAX)) begin
        allred_cnt_nxt = allred_cnt + CNT_W'(1);
      end
    end
  end

  // Lowest code number wins when several checks fire together
  always_comb begin
    code_c = FLT_NONE;
    if (ns_flags_c.enc_err || ew_flags_c.enc_err) begin
      code_c = FLT_ENC;
    end else if (conflict_c) begin
      code_c = FLT_CONFLICT;
    end else if (ns_flags_c.trans_err || ew_flags_c.trans_err) begin
      code_c = FLT_TRANS;
    end else if (ns_flags_c.yel_err || ew_flags_c.yel_err) begin
      code_c = FLT_YELLOW;
    end else if (ns_flags_c.grn_err || ew_flags_c.grn_err) begin
      code_c = FLT_GREEN;
    end else if (allred_err_c) begin
      code_c = FLT_ALLRED;
    end
  end

  // A new fault outranks a simultaneous clear; the code is held until cleared
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fault        <= 1'b0;
      fault_code   <= '0;
      fault_count  <= '0;
      allred_cnt   <= '0;
      allred_fired <= 1'b0;
    end else begin
      allred_cnt   <= allred_cnt_nxt;
      allred_fired <= allred_fired_nxt;
      if (code_c != FLT_NONE) begin
        fault <= 1'b1;
        if (!fault || fault_clr) begin
          fault_code <= code_c;
        end
        if (fault_count != CNT_MAX) begin
          fault_count <= fault_count + CNT_W'(1);
        end
      end else if (fault_clr) begin
        fault      <= 1'b0;
        fault_code <= '0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: vector table, directed multi-cycle cases, random vs reference model.
module tb_traffic_light_monitor;
  import traffic_pkg::*;

  localparam int CNT_W = 8;
  localparam int YT    = 2;
  localparam int TOL   = 1;
  localparam int GM    = 10;
  localparam int AM    = 4;
  localparam int MAXC  = 255;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             tick_1hz = 1'b0;
  logic             fault_clr = 1'b0;
  logic             fault;
  logic [2:0]       fault_code;
  logic [CNT_W-1:0] fault_count, ns_dwell, ew_dwell;

  traffic_light_monitor_if lif();

  traffic_light_monitor dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick_1hz    (tick_1hz),
    .fault_clr   (fault_clr),
    .lights      (lif),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_count (fault_count),
    .ns_dwell    (ns_dwell),
    .ew_dwell    (ew_dwell)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: colours as 0=green, 1=yellow, 2=red; legal step is +1 mod 3
  logic [2:0] m_s[2];
  bit         m_svld;
  int         m_pcol[2];
  bit         m_pv[2];
  int         m_dwell[2];
  bit         m_gf[2];
  int         m_ar;
  bit         m_af;
  int         m_fault, m_code, m_count;

  function automatic int col_of(input logic [2:0] l);
    case (l)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [2:0] bits_of(input int c);
    return (c == 0) ? G : ((c == 1) ? Y : R);
  endfunction

  task automatic model_step(input logic [2:0] ns, input logic [2:0] ew,
                            input bit tick, input bit clr, input bit rst);
    int  code, c;
    bit  enc, conf, trans, yel, grn, both, ar_err, chg;
    if (!rst) begin
      m_s[0] = '0; m_s[1] = '0; m_svld = 0;
      for (int d = 0; d < 2; d++) begin
        m_pcol[d] = 0; m_pv[d] = 0; m_dwell[d] = 0; m_gf[d] = 0;
      end
      m_ar = 0; m_af = 0; m_fault = 0; m_code = 0; m_count = 0;
      return;
    end
    code = 0;
    if (m_svld) begin
      enc = 0; trans = 0; yel = 0; grn = 0;
      for (int d = 0; d < 2; d++) begin
        c   = col_of(m_s[d]);
        chg = 0;
        if (c < 0) begin
          enc = 1;
        end else begin
          chg = m_pv[d] && (c != m_pcol[d]);
          if (chg && (c != (m_pcol[d] + 1) % 3)) trans = 1;
          if (chg && m_pcol[d] == 1 && c == 2 &&
              (m_dwell[d] < YT - TOL || m_dwell[d] > YT + TOL)) yel = 1;
          if (!chg && c == 0 && !m_gf[d] && m_dwell[d] > GM) begin
            grn = 1; m_gf[d] = 1;
          end
          m_pcol[d] = c; m_pv[d] = 1;
        end
        if (chg) begin
          m_dwell[d] = 0; m_gf[d] = 0;
        end else if (tick && m_dwell[d] < MAXC) begin
          m_dwell[d]++;
        end
      end
      conf   = (m_s[0] != R) && (m_s[1] != R);
      both   = (m_s[0] == R) && (m_s[1] == R);
      ar_err = both && !m_af && (m_ar > AM);
      if (both) begin
        if (ar_err) m_af = 1;
        if (tick && m_ar < MAXC) m_ar++;
      end else begin
        m_ar = 0; m_af = 0;
      end
      code = enc ? 1 : conf ? 2 : trans ? 3 : yel ? 4 : grn ? 5 : ar_err ? 6 : 0;
    end
    if (code != 0) begin
      if (m_fault == 0 || clr) m_code = code;
      m_fault = 1;
      if (m_count < MAXC) m_count++;
    end else if (clr) begin
      m_fault = 0; m_code = 0;
    end
    m_s[0] = ns; m_s[1] = ew; m_svld = 1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: drive on negedge, advance model on posedge, compare all outputs just after
  task automatic cyc(input logic [2:0] ns, input logic [2:0] ew,
                     input bit tick = 0, input bit clr = 0, input bit rst = 1);
    @(negedge clk);
    lif.ns_light = ns; lif.ew_light = ew;
    tick_1hz = tick; fault_clr = clr; reset_n = rst;
    @(posedge clk);
    model_step(ns, ew, tick, clr, rst);
    #1;
    n_checks++;
    if (int'(fault) != m_fault || int'(fault_code) != m_code || int'(fault_count) != m_count ||
        int'(ns_dwell) != m_dwell[0] || int'(ew_dwell) != m_dwell[1]) begin
      n_fail++;
      $display("FAIL model_cycle at %0t: got f=%0d c=%0d n=%0d nsd=%0d ewd=%0d, expected f=%0d c=%0d n=%0d nsd=%0d ewd=%0d",
               $time, fault, fault_code, fault_count, ns_dwell, ew_dwell,
               m_fault, m_code, m_count, m_dwell[0], m_dwell[1]);
    end
  endtask

  task automatic do_reset();
    cyc(R, R, 0, 0, 0);
    cyc(R, R, 0, 0, 0);
  endtask

  // Hold a lamp pair for n ticks; dwell of a changed direction is cleared by the second clock
  task automatic hold(input logic [2:0] ns, input logic [2:0] ew, input int n, input bit chk_ns);
    cyc(ns, ew);
    cyc(ns, ew);
    if (chk_ns) check("ns_dwell_cleared", int'(ns_dwell), 0);
    for (int i = 0; i < n; i++) begin
      cyc(ns, ew, 1);
      cyc(ns, ew);
    end
  endtask

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    bit         tick;
    bit         clr;
    bit         rst;
    int         e_fault;
    int         e_code;
    int         e_count;
  } vec_t;

  vec_t tbl[14];
  int   ns_c, ew_c, r;
  logic [2:0] ns_v, ew_v;

  initial begin
    lif.ns_light = R;
    lif.ew_light = R;

    tbl[0]  = '{G, R, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{G, R, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{G, G, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{G, R, 0, 0, 1, 1, 2, 1};
    tbl[4]  = '{G, R, 0, 1, 1, 1, 3, 2};
    tbl[5]  = '{3'b011, G, 0, 1, 1, 0, 0, 2};
    tbl[6]  = '{G, R, 0, 0, 1, 1, 1, 3};
    tbl[7]  = '{G, R, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{R, G, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{R, G, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{R, Y, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{R, R, 0, 0, 1, 0, 0, 0};
    tbl[12] = '{G, R, 0, 0, 1, 1, 4, 1};
    tbl[13] = '{G, R, 0, 0, 1, 1, 4, 1};

    // Vector table
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].ns, tbl[i].ew, tbl[i].tick, tbl[i].clr, tbl[i].rst);
      check($sformatf("tbl%0d_fault", i), int'(fault), tbl[i].e_fault);
      check($sformatf("tbl%0d_code", i), int'(fault_code), tbl[i].e_code);
      check($sformatf("tbl%0d_count", i), int'(fault_count), tbl[i].e_count);
    end

    // Legal sequence, three rounds
    do_reset();
    check("reset_fault", int'(fault), 0);
    check("reset_count", int'(fault_count), 0);
    for (int k = 0; k < 3; k++) begin
      hold(G, R, 5, (k != 0));
      hold(Y, R, 2, 1);
      hold(R, R, 0, 1);
      hold(R, G, 5, 0);
      hold(R, Y, 2, 0);
      hold(R, R, 0, 0);
    end
    check("legal_fault", int'(fault), 0);
    check("legal_count", int'(fault_count), 0);

    // Conflict for one clock
    do_reset();
    hold(G, R, 0, 0);
    cyc(G, G);
    cyc(G, R);
    check("conflict_fault", int'(fault), 1);
    check("conflict_code", int'(fault_code), 2);
    check("conflict_count", int'(fault_count), 1);

    // Illegal G->R, clear, then a yellow held too long
    do_reset();
    hold(G, R, 2, 0);
    hold(R, R, 0, 0);
    check("trans_code", int'(fault_code), 3);
    cyc(R, R, 0, 1);
    check("clr_fault", int'(fault), 0);
    hold(G, R, 1, 0);
    hold(Y, R, 4, 0);
    hold(R, R, 0, 0);
    check("yellow_code", int'(fault_code), 4);
    check("yellow_count", int'(fault_count), 2);

    // Green too long, then all-red too long, no clear in between
    do_reset();
    hold(G, R, 14, 0);
    check("green_code", int'(fault_code), 5);
    check("green_once", int'(fault_count), 1);
    hold(Y, R, 2, 0);
    hold(R, R, 7, 0);
    check("allred_code_held", int'(fault_code), 5);
    check("allred_once", int'(fault_count), 2);

    // Clear racing a conflict, then reset mid-green
    do_reset();
    hold(G, R, 0, 0);
    cyc(G, G);
    cyc(G, R, 0, 1);
    check("race_fault", int'(fault), 1);
    check("race_code", int'(fault_code), 2);
    hold(G, R, 3, 0);
    cyc(G, R, 0, 0, 0);
    check("midrst_fault", int'(fault), 0);
    check("midrst_code", int'(fault_code), 0);
    check("midrst_count", int'(fault_count), 0);
    check("midrst_nsdwell", int'(ns_dwell), 0);
    hold(R, R, 0, 0);
    cyc(R, R);
    check("post_rst_no_fault", int'(fault), 0);

    // Randomised mostly-legal traffic with glitches, clears and rare resets
    do_reset();
    ns_c = 0; ew_c = 2;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 63));
      if (r < 3) ns_c = (ns_c + 1) % 3;
      else if (r < 6) ew_c = (ew_c + 1) % 3;
      ns_v = bits_of(ns_c);
      ew_v = bits_of(ew_c);
      if (r == 6) ns_v = 3'($urandom_range(0, 7));
      if (r == 7) ew_v = 3'($urandom_range(0, 7));
      cyc(ns_v, ew_v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 299) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
